icache_assoc: RTL and testbench
===============================

ICACHE_ASSOC -- requirements
Module: icache_assoc

Interface
REQ-001 The block SHALL have parameter WAYS, default 2, associativity; a power of 2 from 1 to 8.
REQ-002 The block SHALL have parameter SETS, default 16, number of sets; a power of 2 of at least 2.
REQ-003 The block SHALL have parameter LINE_WORDS, default 4, 32-bit words per line; a power of 2 of at least 2.
REQ-004 The block SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-005 Port clk SHALL be input, 1 bit, the clock; all state updates on the rising edge.
REQ-006 Port reset SHALL be input, 1 bit, synchronous, active-high.
REQ-007 Port cpu_valid SHALL be input, 1 bit, fetch request.
REQ-008 Port cpu_addr SHALL be input, ADDR_W bits, fetch byte address; bits [1:0] are ignored.
REQ-009 Port cpu_ready SHALL be output, 1 bit; it marks cpu_data as valid for the current request.
REQ-010 Port cpu_data SHALL be output, 32 bits, the fetched instruction.
REQ-011 Port flush SHALL be input, 1 bit; a one-cycle pulse invalidates all lines.
REQ-012 Port mem_req_valid SHALL be output, 1 bit, line refill request.
REQ-013 Port mem_req_addr SHALL be output, ADDR_W bits, the line-aligned refill address.
REQ-014 Port mem_resp_valid SHALL be input, 1 bit, a one-cycle strobe that the refill data is present.
REQ-015 Port mem_resp_data SHALL be input, 32*LINE_WORDS bits; word k occupies bits [32k+31:32k].
REQ-016 Port hit_cnt SHALL be output, 32 bits, count of hits; it saturates at 0xFFFF_FFFF.
REQ-017 Port miss_cnt SHALL be output, 32 bits, count of misses; it saturates at 0xFFFF_FFFF.

Function
REQ-018 The address split SHALL be: word offset at bits [2+log2(LINE_WORDS)-1:2], index in the next log2(SETS) bits, and tag in the remaining upper bits.
REQ-019 Storage SHALL be held per way and per set: a valid bit, a tag and a line; each set SHALL also hold a log2(WAYS)-bit round-robin pointer.
REQ-020 The FSM SHALL have the states IDLE, FETCH and FLUSH.
REQ-021 In IDLE, a flush SHALL take priority over cpu_valid; the next state is FLUSH and cpu_ready is 0 that cycle.
REQ-022 In IDLE, a hit (cpu_valid=1, and some way is valid with a matching tag) SHALL give cpu_ready=1 in the same cycle, with the addressed word on cpu_data; hit_cnt increments by 1; the state stays IDLE; the pointer is unchanged.
REQ-023 In IDLE, a miss SHALL give cpu_ready=0; the line-aligned address is latched, miss_cnt increments by 1, and the next state is FETCH.
REQ-024 In FETCH, mem_req_valid SHALL be 1 and mem_req_addr SHALL stay constant at the latched address until the cycle of mem_resp_valid, inclusive.
REQ-025 On mem_resp_valid in FETCH, the line SHALL be written to the victim way and that way's valid bit set; cpu_ready=1 in the same cycle, with cpu_data being the requested word forwarded from mem_resp_data; the next state is IDLE.
REQ-026 Victim selection SHALL be the lowest-index invalid way; if no way is invalid, the victim is the way given by the set pointer, and the pointer then increments modulo WAYS.
REQ-027 The requester SHALL hold cpu_valid and cpu_addr stable from request until cpu_ready; the cache need not re-sample cpu_addr during FETCH.
REQ-028 A flush pulse during FETCH SHALL be latched as pending; after the fill completes, the state goes to FLUSH instead of IDLE.
REQ-029 FLUSH SHALL clear the valid bits of all ways in one set per cycle, set indices 0 to SETS-1; this takes exactly SETS cycles, then the state returns to IDLE.
REQ-030 Pointers and counters SHALL be unchanged by a flush.
REQ-031 cpu_ready SHALL be 0 in FLUSH; cpu_valid in FLUSH is neither counted nor serviced.
REQ-032 mem_resp_valid outside FETCH SHALL be ignored.
REQ-033 A counter at its maximum SHALL hold at its maximum.
REQ-034 When WAYS=1, the pointer SHALL be zero-width and the victim SHALL always be way 0.

Reset
REQ-035 On reset, the state SHALL go to IDLE, with all valid bits 0, all pointers 0, the pending flush cleared, hit_cnt=0 and miss_cnt=0.
REQ-036 On reset, cpu_ready=0, cpu_data=0, mem_req_valid=0 and mem_req_addr=0.
REQ-037 Reset during FETCH or FLUSH SHALL abandon the operation; mem_req_valid is 0 from the next cycle onward.

Verification (default parameters)
REQ-038 Cold miss: cpu_addr=0x0000_0104 is a miss, so mem_req_valid=1 and mem_req_addr=0x0000_0100 from the next cycle; a response with words 0xA0,0xA1,0xA2,0xA3 gives cpu_ready=1 and cpu_data=0xA1 that cycle; then cpu_addr=0x0000_0108 gives a same-cycle hit with cpu_data=0xA2; the counts are hit_cnt=1 and miss_cnt=1.
REQ-039 Replacement: fill 0x000, 0x100 and 0x200 (all set 0); 0x200 evicts way 0; then 0x100 hits and 0x000 misses, and that miss evicts way 1.
REQ-040 Slow memory: mem_resp_valid is delayed 10 cycles; mem_req_valid and mem_req_addr stay stable for all 11 cycles, and there is a single fill.
REQ-041 Flush: after filling 0x100, a one-cycle flush pulse gives cpu_ready=0 for 16 cycles; then 0x100 misses; the counters keep their values.
REQ-042 Flush during FETCH: the fill completes with cpu_ready=1 and then FLUSH runs; a subsequent access to the same line misses.
REQ-043 Reset mid-FETCH: mem_req_valid=0 the cycle after reset; a late mem_resp_valid is ignored; 0x100 then misses, with miss_cnt=1.

Source files
------------

// File: rtl/icache_assoc.sv
// icache_assoc: set-associative instruction cache with round-robin refill, flush walk and hit/miss counters
module icache_assoc #(
  parameter int WAYS = 2,
  parameter int SETS = 16,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_valid,
  input  logic [ADDR_W-1:0]        cpu_addr,
  output logic                     cpu_ready,
  output logic [31:0]              cpu_data,
  input  logic                     flush,
  output logic                     mem_req_valid,
  output logic [ADDR_W-1:0]        mem_req_addr,
  input  logic                     mem_resp_valid,
  input  logic [32*LINE_WORDS-1:0] mem_resp_data,
  output logic [31:0]              hit_cnt,
  output logic [31:0]              miss_cnt
);
  localparam int OW = $clog2(LINE_WORDS);
  localparam int IW = $clog2(SETS);
  localparam int TW = ADDR_W - 2 - OW - IW;
  localparam int LW = 32 * LINE_WORDS;
  localparam int WW = WAYS > 1 ? $clog2(WAYS) : 1;
  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;
  state_t state, state_nx;
  logic [WAYS-1:0] valid [SETS];
  logic [TW-1:0] tags [WAYS][SETS];
  logic [LW-1:0] lines [WAYS][SETS];
  logic [ADDR_W-3:0] lat_addr;
  logic pend;
  logic [IW-1:0] fidx;
  logic [OW-1:0] req_off, fill_off;
  logic [IW-1:0] req_idx, fill_idx;
  logic [TW-1:0] req_tag, fill_tag;
  logic hit, has_inv, hit_ev, miss, fill;
  logic [LW-1:0] hit_line;
  logic [WW-1:0] victim, ptr_cur;
  logic unused_bits;
  assign unused_bits = ^cpu_addr[1:0];
  assign req_off = cpu_addr[2+:OW];
  assign req_idx = cpu_addr[2+OW+:IW];
  assign req_tag = cpu_addr[ADDR_W-1-:TW];
  assign fill_off = lat_addr[0+:OW];
  assign fill_idx = lat_addr[OW+:IW];
  assign fill_tag = lat_addr[ADDR_W-3-:TW];
  always_comb begin
    hit = 1'b0;
    hit_line = '0;
    for (int w = 0; w < WAYS; w++)
      if (valid[req_idx][w] && tags[w][req_idx] == req_tag) begin
        hit = 1'b1;
        hit_line = lines[w][req_idx];
      end
  end
  // Scanning downward leaves the lowest-index invalid way as the victim
  always_comb begin
    victim = ptr_cur;
    has_inv = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid[fill_idx][w]) begin
        victim = w[WW-1:0];
        has_inv = 1'b1;
      end
  end
  assign hit_ev = state == IDLE && !flush && cpu_valid && hit;
  assign miss = state == IDLE && !flush && cpu_valid && !hit;
  assign fill = state == FETCH && mem_resp_valid;
  assign cpu_ready = !reset && (hit_ev || fill);
  assign cpu_data = !cpu_ready ? 32'd0 : fill ? mem_resp_data[32*fill_off+:32] : hit_line[32*req_off+:32];
  assign mem_req_valid = state == FETCH;
  assign mem_req_addr = {lat_addr[ADDR_W-3:OW], {(2+OW){1'b0}}};
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = flush ? FLUSH : miss ? FETCH : IDLE;
      FETCH:   state_nx = !mem_resp_valid ? FETCH : (pend || flush) ? FLUSH : IDLE;
      FLUSH:   state_nx = fidx == IW'(SETS - 1) ? IDLE : FLUSH;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    state <= reset ? IDLE : state_nx;
    pend <= reset || fill ? 1'b0 : (state == FETCH && flush) ? 1'b1 : pend;
    fidx <= reset ? '0 : state == FLUSH ? fidx + 1'b1 : fidx;
    lat_addr <= reset ? '0 : miss ? cpu_addr[ADDR_W-1:2] : lat_addr;
    hit_cnt <= reset ? '0 : hit_cnt + 32'(hit_ev && ~&hit_cnt);
    miss_cnt <= reset ? '0 : miss_cnt + 32'(miss && ~&miss_cnt);
  end
  always_ff @(posedge clk)
    if (reset)
      for (int s = 0; s < SETS; s++) valid[s] <= '0;
    else if (state == FLUSH)
      valid[fidx] <= '0;
    else if (fill)
      valid[fill_idx][victim] <= 1'b1;
  always_ff @(posedge clk)
    if (!reset && fill) begin
      tags[victim][fill_idx] <= fill_tag;
      lines[victim][fill_idx] <= mem_resp_data;
    end
  generate
    if (WAYS > 1) begin : g_ptr
      logic [WW-1:0] ptr [SETS];
      always_ff @(posedge clk)
        if (reset)
          for (int s = 0; s < SETS; s++) ptr[s] <= '0;
        else if (fill && !has_inv)
          ptr[fill_idx] <= ptr[fill_idx] + 1'b1;
      assign ptr_cur = ptr[fill_idx];
    end else begin : g_no_ptr
      assign ptr_cur = '0;
    end
  endgenerate
endmodule

// File: tb/tb_icache_assoc.sv
// tb_icache_assoc: directed checks of hit/miss, replacement, slow refill, flush and reset behaviour
module tb_icache_assoc;
  logic clk, reset, cpu_valid, cpu_ready, flush, mem_req_valid, mem_resp_valid;
  logic [31:0] cpu_addr, cpu_data, mem_req_addr, hit_cnt, miss_cnt;
  logic [127:0] mem_resp_data;
  int checks = 0;
  int failures = 0;
  icache_assoc dut (
    .clk(clk), .reset(reset), .cpu_valid(cpu_valid), .cpu_addr(cpu_addr),
    .cpu_ready(cpu_ready), .cpu_data(cpu_data), .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    cpu_valid = 1'b0;
    flush = 1'b0;
    mem_resp_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask
  // Line data: word k = base + k
  task automatic access(input logic [31:0] a, input bit exp_hit, input logic [31:0] base, input int delay);
    cpu_valid = 1'b1;
    cpu_addr = a;
    #1;
    if (exp_hit) begin
      chk("hit_rdy", {31'd0, cpu_ready}, 32'd1);
      chk("hit_data", cpu_data, base + a[3:2]);
    end else begin
      chk("miss_rdy", {31'd0, cpu_ready}, 32'd0);
      tick();
      for (int i = 0; i <= delay; i++) begin
        if (i == delay) begin
          mem_resp_valid = 1'b1;
          mem_resp_data = {base + 32'd3, base + 32'd2, base + 32'd1, base};
        end
        #1;
        chk("req_valid", {31'd0, mem_req_valid}, 32'd1);
        chk("req_addr", mem_req_addr, {a[31:4], 4'h0});
        if (i < delay) begin
          chk("wait_rdy", {31'd0, cpu_ready}, 32'd0);
          tick();
        end
      end
      chk("fill_rdy", {31'd0, cpu_ready}, 32'd1);
      chk("fill_data", cpu_data, base + a[3:2]);
    end
    tick();
    cpu_valid = 1'b0;
    mem_resp_valid = 1'b0;
  endtask
  initial begin
    cpu_addr = '0;
    mem_resp_data = '0;
    do_reset();
    #1;
    chk("rst_rdy", {31'd0, cpu_ready}, 32'd0);
    chk("rst_data", cpu_data, 32'd0);
    chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_req_addr", mem_req_addr, 32'd0);
    chk("rst_hits", hit_cnt, 32'd0);
    chk("rst_misses", miss_cnt, 32'd0);
    tick();
    // Cold miss then same-line hit
    access(32'h104, 1'b0, 32'hA0, 0);
    access(32'h108, 1'b1, 32'hA0, 0);
    chk("cold_hits", hit_cnt, 32'd1);
    chk("cold_misses", miss_cnt, 32'd1);
    // Replacement in set 0
    do_reset();
    access(32'h000, 1'b0, 32'hD000_0000, 0);
    access(32'h100, 1'b0, 32'hD000_0100, 0);
    access(32'h200, 1'b0, 32'hD000_0200, 0);
    access(32'h104, 1'b1, 32'hD000_0100, 0);
    access(32'h000, 1'b0, 32'hD000_0000, 0);
    access(32'h208, 1'b1, 32'hD000_0200, 0);
    access(32'h00C, 1'b1, 32'hD000_0000, 0);
    access(32'h100, 1'b0, 32'hD000_0110, 0);
    chk("repl_hits", hit_cnt, 32'd3);
    chk("repl_misses", miss_cnt, 32'd5);
    // Slow memory: 10-cycle response delay, single fill
    do_reset();
    access(32'h344, 1'b0, 32'h5100, 10);
    access(32'h348, 1'b1, 32'h5100, 0);
    chk("slow_misses", miss_cnt, 32'd1);
    // Flush from IDLE
    do_reset();
    access(32'h100, 1'b0, 32'hF00, 0);
    access(32'h104, 1'b1, 32'hF00, 0);
    cpu_valid = 1'b1;
    cpu_addr = 32'h100;
    flush = 1'b1;
    #1;
    chk("flush_pri_rdy", {31'd0, cpu_ready}, 32'd0);
    tick();
    flush = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("flush_rdy", {31'd0, cpu_ready}, 32'd0);
      tick();
    end
    chk("flush_hits", hit_cnt, 32'd1);
    chk("flush_misses", miss_cnt, 32'd1);
    access(32'h100, 1'b0, 32'hF10, 0);
    chk("post_flush_misses", miss_cnt, 32'd2);
    // Flush during FETCH
    do_reset();
    access(32'h020, 1'b0, 32'h700, 0);
    cpu_valid = 1'b1;
    cpu_addr = 32'h104;
    #1;
    chk("ff_miss_rdy", {31'd0, cpu_ready}, 32'd0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data = {32'h803, 32'h802, 32'h801, 32'h800};
    #1;
    chk("ff_fill_rdy", {31'd0, cpu_ready}, 32'd1);
    chk("ff_fill_data", cpu_data, 32'h801);
    tick();
    mem_resp_valid = 1'b0;
    cpu_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("ff_flush_req", {31'd0, mem_req_valid}, 32'd0);
      tick();
    end
    access(32'h104, 1'b0, 32'h900, 0);
    access(32'h020, 1'b0, 32'h710, 0);
    chk("ff_misses", miss_cnt, 32'd4);
    // Reset mid-FETCH, late response ignored
    do_reset();
    cpu_valid = 1'b1;
    cpu_addr = 32'h100;
    tick();
    chk("mid_req_valid", {31'd0, mem_req_valid}, 32'd1);
    reset = 1'b1;
    cpu_valid = 1'b0;
    tick();
    chk("mid_rst_req", {31'd0, mem_req_valid}, 32'd0);
    reset = 1'b0;
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_data = {4{32'hBAD0_0000}};
    #1;
    chk("late_resp_rdy", {31'd0, cpu_ready}, 32'd0);
    tick();
    mem_resp_valid = 1'b0;
    chk("late_resp_req", {31'd0, mem_req_valid}, 32'd0);
    chk("mid_misses0", miss_cnt, 32'd0);
    access(32'h100, 1'b0, 32'hC00, 0);
    chk("mid_misses1", miss_cnt, 32'd1);
    chk("mid_hits", hit_cnt, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
